// File: rtl/ttc_counter_lite29_if.sv
// Register-select bus and event/readback signals of the TTC counter.
// The master drives the decoded APB write strobes; the slave is the counter.
interface ttc_counter_lite29_if;
  logic [15:0] pwdata29;
  logic        cntr_ctrl_reg_sel29;
  logic        clk_ctrl_reg_sel29;
  logic        interval_reg_sel29;
  logic        match_1_reg_sel29;
  logic        match_2_reg_sel29;
  logic        match_3_reg_sel29;
  logic [15:0] counter_val_out29;
  logic [4:0]  cntr_ctrl_out29;
  logic [4:0]  clk_ctrl_out29;
  logic [15:0] interval_out29;
  logic        interval_intr29;
  logic [3:1]  match_intr29;
  logic        overflow_intr29;
  logic        restart29;

  modport master (
    output pwdata29, cntr_ctrl_reg_sel29, clk_ctrl_reg_sel29, interval_reg_sel29,
           match_1_reg_sel29, match_2_reg_sel29, match_3_reg_sel29,
    input  counter_val_out29, cntr_ctrl_out29, clk_ctrl_out29, interval_out29,
           interval_intr29, match_intr29, overflow_intr29, restart29
  );

  modport slave (
    input  pwdata29, cntr_ctrl_reg_sel29, clk_ctrl_reg_sel29, interval_reg_sel29,
           match_1_reg_sel29, match_2_reg_sel29, match_3_reg_sel29,
    output counter_val_out29, cntr_ctrl_out29, clk_ctrl_out29, interval_out29,
           interval_intr29, match_intr29, overflow_intr29, restart29
  );
endinterface

// File: rtl/ttc_counter_lite29.sv
// TTC timer/counter: power-of-two prescaler, 16-bit up/down counter with
// interval and overflow modes, three match comparators and restart.
module ttc_counter_lite29 (
  input logic                  pclk29,
  input logic                  n_p_reset29,
  ttc_counter_lite29_if.slave  bus
);

  logic [3:0]  ctrl_q;
  logic [4:0]  clk_ctrl_q;
  logic [15:0] interval_q;
  logic [15:0] match1_q, match2_q, match3_q;
  logic [15:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic        restart_pend_q;
  logic        interval_intr_q, interval_intr_d;
  logic        overflow_intr_q, overflow_intr_d;
  logic [3:1]  match_intr_q, match_intr_d;
  logic        restart_q, restart_d;
  logic        tick;

  // Terminal prescaler value 2^(N+1)-1; N=15 yields FFFF.
  function automatic logic [15:0] presc_limit(input logic [3:0] n);
    logic [16:0] v;
    v = (17'd2 << n) - 17'd1;
    return v[15:0];
  endfunction

  function automatic logic [15:0] restart_load(input logic [3:0] ctrl, input logic [15:0] intv);
    if (!ctrl[2])     return 16'h0000;
    else if (ctrl[1]) return intv;
    else              return 16'hFFFF;
  endfunction

  always_ff @(posedge pclk29 or negedge n_p_reset29) begin
    if (!n_p_reset29) begin
      ctrl_q         <= 4'b0001;
      clk_ctrl_q     <= '0;
      interval_q     <= 16'hFFFF;
      match1_q       <= '0;
      match2_q       <= '0;
      match3_q       <= '0;
      restart_pend_q <= 1'b0;
    end else begin
      // Restart is a strobe only; the load happens on the following edge.
      restart_pend_q <= bus.cntr_ctrl_reg_sel29 & bus.pwdata29[4];
      if (bus.cntr_ctrl_reg_sel29) ctrl_q     <= bus.pwdata29[3:0];
      if (bus.clk_ctrl_reg_sel29)  clk_ctrl_q <= bus.pwdata29[4:0];
      if (bus.interval_reg_sel29)  interval_q <= bus.pwdata29;
      if (bus.match_1_reg_sel29)   match1_q   <= bus.pwdata29;
      if (bus.match_2_reg_sel29)   match2_q   <= bus.pwdata29;
      if (bus.match_3_reg_sel29)   match3_q   <= bus.pwdata29;
    end
  end

  always_comb begin
    tick            = 1'b0;
    presc_d         = presc_q;
    count_d         = count_q;
    interval_intr_d = 1'b0;
    overflow_intr_d = 1'b0;
    match_intr_d    = '0;
    restart_d       = 1'b0;
    if (restart_pend_q) begin
      // Restart wins over any coincident tick and suppresses its events.
      presc_d   = '0;
      restart_d = 1'b1;
      count_d   = restart_load(ctrl_q, interval_q);
    end else if (!ctrl_q[0]) begin
      if (clk_ctrl_q[0]) begin
        if (presc_q == presc_limit(clk_ctrl_q[4:1])) begin
          tick    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end else begin
        tick = 1'b1;
      end
      if (tick) begin
        if (!ctrl_q[2]) begin
          if (ctrl_q[1] && (count_q == interval_q)) begin
            count_d         = '0;
            interval_intr_d = 1'b1;
          end else if (count_q == 16'hFFFF) begin
            count_d         = '0;
            overflow_intr_d = 1'b1;
          end else begin
            count_d = count_q + 16'd1;
          end
        end else begin
          if (count_q == 16'h0000) begin
            if (ctrl_q[1]) begin
              count_d         = interval_q;
              interval_intr_d = 1'b1;
            end else begin
              count_d         = 16'hFFFF;
              overflow_intr_d = 1'b1;
            end
          end else begin
            count_d = count_q - 16'd1;
          end
        end
        if (ctrl_q[3]) begin
          match_intr_d[1] = (count_d == match1_q);
          match_intr_d[2] = (count_d == match2_q);
          match_intr_d[3] = (count_d == match3_q);
        end
      end
    end
  end

  always_ff @(posedge pclk29 or negedge n_p_reset29) begin
    if (!n_p_reset29) begin
      count_q         <= '0;
      presc_q         <= '0;
      interval_intr_q <= 1'b0;
      overflow_intr_q <= 1'b0;
      match_intr_q    <= '0;
      restart_q       <= 1'b0;
    end else begin
      count_q         <= count_d;
      presc_q         <= presc_d;
      interval_intr_q <= interval_intr_d;
      overflow_intr_q <= overflow_intr_d;
      match_intr_q    <= match_intr_d;
      restart_q       <= restart_d;
    end
  end

  assign bus.counter_val_out29 = count_q;
  assign bus.cntr_ctrl_out29   = {1'b0, ctrl_q};
  assign bus.clk_ctrl_out29    = clk_ctrl_q;
  assign bus.interval_out29    = interval_q;
  assign bus.interval_intr29   = interval_intr_q;
  assign bus.overflow_intr29   = overflow_intr_q;
  assign bus.match_intr29      = match_intr_q;
  assign bus.restart29         = restart_q;

endmodule

// File: tb/tb_ttc_counter_lite29.sv
// Scoreboard bench for ttc_counter_lite29: a cycle model queues expected
// outputs on each edge; the opposite edge pops and compares them.
module tb_ttc_counter_lite29;

  logic pclk29 = 1'b0;
  logic n_p_reset29 = 1'b0;
  ttc_counter_lite29_if bus();

  ttc_counter_lite29 dut (.pclk29(pclk29), .n_p_reset29(n_p_reset29), .bus(bus));

  always #5 pclk29 = ~pclk29;

  typedef struct {
    logic [15:0] cnt;
    logic [5:0]  ev;   // {restart, overflow, interval, match[3:1]}
    logic [25:0] rb;   // {ctrl, clk_ctrl, interval}
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int ovf_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_ctrl, m_clk, m_int, m_cnt, m_pre, m_rpend;
  int m_match[1:3];

  always @(posedge pclk29 or negedge n_p_reset29) begin
    if (!n_p_reset29) begin
      m_ctrl = 1; m_clk = 0; m_int = 65535; m_cnt = 0; m_pre = 0; m_rpend = 0;
      for (int i = 1; i <= 3; i++) m_match[i] = 0;
      sb.delete();
    end else begin
      exp_t e;
      int nc, period;
      bit tk, iv, ov, rs;
      logic [3:1] mt;
      nc = m_cnt; tk = 0; iv = 0; ov = 0; rs = 0; mt = '0;
      if (m_rpend != 0) begin
        rs = 1; m_pre = 0;
        if ((m_ctrl & 4) == 0)      nc = 0;
        else if ((m_ctrl & 2) != 0) nc = m_int;
        else                        nc = 65535;
      end else if ((m_ctrl & 1) == 0) begin
        if ((m_clk & 1) != 0) begin
          period = 1 << ((m_clk >> 1) + 1);
          if (m_pre == period - 1) begin tk = 1; m_pre = 0; end
          else m_pre = m_pre + 1;
        end else tk = 1;
        if (tk) begin
          if ((m_ctrl & 4) == 0) begin
            if ((m_ctrl & 2) != 0 && m_cnt == m_int) begin nc = 0; iv = 1; end
            else if (m_cnt == 65535) begin nc = 0; ov = 1; end
            else nc = m_cnt + 1;
          end else begin
            if (m_cnt == 0) begin
              if ((m_ctrl & 2) != 0) begin nc = m_int; iv = 1; end
              else begin nc = 65535; ov = 1; end
            end else nc = m_cnt - 1;
          end
          if ((m_ctrl & 8) != 0)
            for (int i = 1; i <= 3; i++) mt[i] = (nc == m_match[i]);
        end
      end
      m_cnt = nc;
      m_rpend = (bus.cntr_ctrl_reg_sel29 && bus.pwdata29[4]) ? 1 : 0;
      if (bus.cntr_ctrl_reg_sel29) m_ctrl = int'(bus.pwdata29[3:0]);
      if (bus.clk_ctrl_reg_sel29)  m_clk  = int'(bus.pwdata29[4:0]);
      if (bus.interval_reg_sel29)  m_int  = int'(bus.pwdata29);
      if (bus.match_1_reg_sel29)   m_match[1] = int'(bus.pwdata29);
      if (bus.match_2_reg_sel29)   m_match[2] = int'(bus.pwdata29);
      if (bus.match_3_reg_sel29)   m_match[3] = int'(bus.pwdata29);
      e.cnt = m_cnt[15:0];
      e.ev  = {rs, ov, iv, mt};
      e.rb  = {1'b0, m_ctrl[3:0], m_clk[4:0], m_int[15:0]};
      sb.push_back(e);
    end
  end

  always @(negedge pclk29) begin
    if (n_p_reset29 && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("count", {16'h0, bus.counter_val_out29}, {16'h0, e.cnt});
      chk("events", {26'h0, bus.restart29, bus.overflow_intr29, bus.interval_intr29, bus.match_intr29},
          {26'h0, e.ev});
      chk("readback", {6'h0, bus.cntr_ctrl_out29, bus.clk_ctrl_out29, bus.interval_out29}, {6'h0, e.rb});
      if (bus.overflow_intr29) ovf_seen++;
    end
  end

  task automatic wr(input int sel, input logic [15:0] d);
    @(negedge pclk29);
    bus.pwdata29 = d;
    case (sel)
      0: bus.cntr_ctrl_reg_sel29 = 1'b1;
      1: bus.clk_ctrl_reg_sel29  = 1'b1;
      2: bus.interval_reg_sel29  = 1'b1;
      3: bus.match_1_reg_sel29   = 1'b1;
      4: bus.match_2_reg_sel29   = 1'b1;
      default: bus.match_3_reg_sel29 = 1'b1;
    endcase
    @(negedge pclk29);
    bus.cntr_ctrl_reg_sel29 = 1'b0;
    bus.clk_ctrl_reg_sel29  = 1'b0;
    bus.interval_reg_sel29  = 1'b0;
    bus.match_1_reg_sel29   = 1'b0;
    bus.match_2_reg_sel29   = 1'b0;
    bus.match_3_reg_sel29   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cnt"}, {16'h0, bus.counter_val_out29}, 32'h0);
    chk({tag, "_ctrl"}, {27'h0, bus.cntr_ctrl_out29}, 32'h1);
    chk({tag, "_clk"}, {27'h0, bus.clk_ctrl_out29}, 32'h0);
    chk({tag, "_intv"}, {16'h0, bus.interval_out29}, 32'hFFFF);
    chk({tag, "_ev"}, {26'h0, bus.restart29, bus.overflow_intr29, bus.interval_intr29, bus.match_intr29}, 32'h0);
  endtask

  task automatic watch_match(input string tag, input logic [3:1] at3, input logic [3:1] at7);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk29);
      if (bus.counter_val_out29 == 16'd3) chk({tag, "_at3"}, {29'h0, bus.match_intr29}, {29'h0, at3});
      if (bus.counter_val_out29 == 16'd7) chk({tag, "_at7"}, {29'h0, bus.match_intr29}, {29'h0, at7});
    end
  endtask

  initial begin
    bit found;
    bus.pwdata29 = '0;
    bus.cntr_ctrl_reg_sel29 = 1'b0;
    bus.clk_ctrl_reg_sel29  = 1'b0;
    bus.interval_reg_sel29  = 1'b0;
    bus.match_1_reg_sel29   = 1'b0;
    bus.match_2_reg_sel29   = 1'b0;
    bus.match_3_reg_sel29   = 1'b0;
    repeat (3) @(negedge pclk29);
    check_reset_state("rst");
    n_p_reset29 = 1'b1;
    repeat (3) @(negedge pclk29);

    // Free-running increment through a full wrap
    wr(0, 16'h0000);
    ovf_seen = 0;
    repeat (65540) @(negedge pclk29);
    chk("ovf_once", ovf_seen, 1);

    // Interval mode, up then down
    wr(2, 16'd5);
    wr(0, 16'h0012);
    repeat (14) @(negedge pclk29);
    wr(0, 16'h0016);
    repeat (14) @(negedge pclk29);

    // Match comparators, enabled then disabled
    wr(3, 16'd3);
    wr(4, 16'd3);
    wr(5, 16'd7);
    wr(0, 16'h0018);
    watch_match("men", 3'b011, 3'b100);
    wr(0, 16'h0010);
    watch_match("mdis", 3'b000, 3'b000);

    // Prescale N=1 with a mid-period restart
    wr(1, 16'h0003);
    wr(0, 16'h0010);
    repeat (9) @(negedge pclk29);
    wr(0, 16'h0010);
    repeat (10) @(negedge pclk29);
    wr(1, 16'h0000);

    // Restart coinciding with the interval wrap tick
    wr(0, 16'h0012);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge pclk29);
      if (bus.counter_val_out29 == 16'd4) found = 1;
    end
    chk("wait_cnt4", {31'h0, found}, 32'h1);
    bus.pwdata29 = 16'h0012;
    bus.cntr_ctrl_reg_sel29 = 1'b1;
    @(negedge pclk29);
    bus.cntr_ctrl_reg_sel29 = 1'b0;
    chk("pre_rst_cnt", {16'h0, bus.counter_val_out29}, 32'd5);
    @(negedge pclk29);
    chk("rst_cnt", {16'h0, bus.counter_val_out29}, 32'd0);
    chk("rst_pulse", {31'h0, bus.restart29}, 32'h1);
    chk("rst_no_intv", {31'h0, bus.interval_intr29}, 32'h0);

    // Asynchronous reset mid-count
    repeat (5) @(negedge pclk29);
    #2 n_p_reset29 = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge pclk29);
    n_p_reset29 = 1'b1;
    repeat (5) @(negedge pclk29);
    chk("held_cnt", {16'h0, bus.counter_val_out29}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
